// File: rtl/prim_onehot_mux_pipe_pkg.sv
// Shared types and helpers for the registered one-hot mux pipeline.
// Holds the skid-buffer state encoding and the select legality check.
package prim_onehot_mux_pipe_pkg;

    localparam int MaxInputs = 64;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    // True when more than one select bit is set, or none and zero-hot is disallowed.
    function automatic logic sel_illegal(
        input logic [MaxInputs-1:0] sel,
        input logic                 zero_ok
    );
        logic [6:0] ones;
        ones = '0;
        for (int i = 0; i < MaxInputs; i++) begin
            ones += {6'd0, sel[i]};
        end
        return (ones > 7'd1) || ((ones == 7'd0) && !zero_ok);
    endfunction

endpackage

// File: rtl/prim_onehot_mux_pipe_skid.sv
// Two-entry skid buffer (main + skid register) with a registered ready.
// One cycle from accept to valid_o; beats drain strictly in order.
module prim_skid_buf
    import prim_onehot_mux_pipe_pkg::*;
#(
    parameter int Width = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o
);

    skid_state_e      state_q;
    skid_state_e      state_d;
    logic [Width-1:0] main_q;
    logic [Width-1:0] skid_q;
    logic             ready_q;
    logic             accept;

    assign accept = valid_i && ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
                if (accept && !ready_i) state_d = ST_TWO;
                else if (!accept && ready_i) state_d = ST_EMPTY;
            end
            ST_TWO: if (ready_i) state_d = ST_ONE;
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (accept) main_q <= data_i;
                ST_ONE: begin
                    if (accept && ready_i) main_q <= data_i;
                    if (accept && !ready_i) skid_q <= data_i;
                end
                ST_TWO: if (ready_i) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        valid_o = (state_q != ST_EMPTY);
        ready_o = ready_q;
        data_o  = main_q;
    end

endmodule

// File: rtl/prim_onehot_mux_pipe.sv
// AND-OR one-hot mux feeding a skid buffer, with select-error reporting.
// Illegal selects still pass the OR of the selected channels downstream.
module prim_onehot_mux_pipe
    import prim_onehot_mux_pipe_pkg::*;
#(
    parameter int Width     = 32,
    parameter int Inputs    = 8,
    parameter bit ZeroHotOk = 1'b0,
    parameter int CntWidth  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [Inputs*Width-1:0] in_i,
    input  logic [Inputs-1:0]       sel_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [Width-1:0]        out_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    err_o,
    output logic                    err_sticky_o,
    output logic [CntWidth-1:0]     err_cnt_o,
    input  logic                    err_clr_i
);

    logic [Width-1:0] mux_data;
    logic [Width:0]   buf_data;
    logic             illegal;
    logic             accept;
    logic             new_err;
    logic             unused_beat_err;

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < Inputs; i++) begin
            mux_data |= in_i[((Inputs-1-i)*Width) +: Width] & {Width{sel_i[i]}};
        end
    end

    assign illegal = sel_illegal(MaxInputs'(sel_i), ZeroHotOk);
    assign accept  = valid_i && ready_o;
    assign new_err = accept && illegal;

    prim_skid_buf #(
        .Width(Width + 1)
    ) u_skid (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i ({illegal, mux_data}),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_o (buf_data)
    );

    assign out_o           = buf_data[Width-1:0];
    assign unused_beat_err = buf_data[Width];

    // A clear in the same cycle as a new error leaves exactly that error counted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o        <= 1'b0;
            err_sticky_o <= 1'b0;
            err_cnt_o    <= '0;
        end else begin
            err_o <= new_err;
            if (err_clr_i) begin
                err_sticky_o <= new_err;
                err_cnt_o    <= new_err ? CntWidth'(1) : '0;
            end else if (new_err) begin
                err_sticky_o <= 1'b1;
                if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CntWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_prim_onehot_mux_pipe.sv
// Directed bench: two instances share stimulus, one strict (CntWidth=2),
// one allowing zero-hot selects.
module tb_prim_onehot_mux_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_d = '0;
    logic [3:0]  sel = '0;
    logic        valid = 1'b0;
    logic        rdy = 1'b1;
    logic        clr = 1'b0;

    logic       a_ready, a_valid, a_err, a_sticky;
    logic [7:0] a_out;
    logic [1:0] a_cnt;
    logic       b_ready, b_valid, b_err, b_sticky;
    logic [7:0] b_out;
    logic [7:0] b_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prim_onehot_mux_pipe #(
        .Width(8), .Inputs(4), .ZeroHotOk(1'b0), .CntWidth(2)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .in_i(in_d), .sel_i(sel),
        .valid_i(valid), .ready_o(a_ready), .out_o(a_out),
        .valid_o(a_valid), .ready_i(rdy), .err_o(a_err),
        .err_sticky_o(a_sticky), .err_cnt_o(a_cnt), .err_clr_i(clr)
    );

    prim_onehot_mux_pipe #(
        .Width(8), .Inputs(4), .ZeroHotOk(1'b1), .CntWidth(8)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .in_i(in_d), .sel_i(sel),
        .valid_i(valid), .ready_o(b_ready), .out_o(b_out),
        .valid_o(b_valid), .ready_i(rdy), .err_o(b_err),
        .err_sticky_o(b_sticky), .err_cnt_o(b_cnt), .err_clr_i(clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; rdy = 1'b1; clr = 1'b0;
        tick(); tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", a_valid); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", a_ready); end
        checks++; if (a_out !== 8'h00) begin errors++; $display("FAIL rst_out got %h want 00", a_out); end
        checks++; if ({a_err, a_sticky, a_cnt} !== 4'b0) begin errors++; $display("FAIL rst_err got %b want 0000", {a_err, a_sticky, a_cnt}); end
        rst = 1'b0;
        tick();
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b want 1", a_ready); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rel_ready_b got %b want 1", b_ready); end
    endtask

    task automatic test_single();
        in_d = {8'h11, 8'h22, 8'h33, 8'h44}; sel = 4'b0100; valid = 1'b1; rdy = 1'b1;
        tick();
        valid = 1'b0;
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", a_valid); end
        checks++; if (a_out !== 8'h33) begin errors++; $display("FAIL single_out got %h want 33", a_out); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", a_err); end
        tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", a_valid); end
    endtask

    task automatic test_multihot();
        in_d = {8'h00, 8'h0F, 8'hF0, 8'h00}; sel = 4'b0110; valid = 1'b1;
        tick();
        valid = 1'b0;
        checks++; if (a_out !== 8'hFF) begin errors++; $display("FAIL multi_out got %h want ff", a_out); end
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL multi_err got %b want 1", a_err); end
        checks++; if (a_cnt !== 2'd1) begin errors++; $display("FAIL multi_cnt got %0d want 1", a_cnt); end
        checks++; if (a_sticky !== 1'b1) begin errors++; $display("FAIL multi_sticky got %b want 1", a_sticky); end
        tick();
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL multi_pulse got %b want 0", a_err); end
        checks++; if (a_sticky !== 1'b1) begin errors++; $display("FAIL multi_hold got %b want 1", a_sticky); end
    endtask

    task automatic test_zero_hot();
        in_d = {8'h11, 8'h22, 8'h33, 8'h44}; sel = 4'b0000; valid = 1'b1;
        tick();
        valid = 1'b0;
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL zero_err_a got %b want 1", a_err); end
        checks++; if (a_out !== 8'h00) begin errors++; $display("FAIL zero_out_a got %h want 00", a_out); end
        checks++; if (a_cnt !== 2'd2) begin errors++; $display("FAIL zero_cnt_a got %0d want 2", a_cnt); end
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL zero_err_b got %b want 0", b_err); end
        checks++; if (b_valid !== 1'b1 || b_out !== 8'h00) begin errors++; $display("FAIL zero_out_b got %b/%h want 1/00", b_valid, b_out); end
        checks++; if (b_cnt !== 8'd1) begin errors++; $display("FAIL zero_cnt_b got %0d want 1", b_cnt); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if ({a_sticky, a_cnt} !== 3'b000) begin errors++; $display("FAIL clr_a got %b want 000", {a_sticky, a_cnt}); end
        checks++; if (b_sticky !== 1'b0 || b_cnt !== 8'd0) begin errors++; $display("FAIL clr_b got %b/%0d want 0/0", b_sticky, b_cnt); end
    endtask

    task automatic test_back_to_back();
        in_d = {8'h11, 8'h22, 8'h33, 8'h44}; rdy = 1'b0; valid = 1'b1; sel = 4'b0001;
        tick();
        checks++; if (a_valid !== 1'b1 || a_out !== 8'h11) begin errors++; $display("FAIL b2b_first got %b/%h want 1/11", a_valid, a_out); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b want 1", a_ready); end
        sel = 4'b0010;
        tick();
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready2 got %b want 0", a_ready); end
        checks++; if (a_out !== 8'h11) begin errors++; $display("FAIL b2b_hold got %h want 11", a_out); end
        sel = 4'b1000;
        tick();
        checks++; if (a_ready !== 1'b0 || a_out !== 8'h11) begin errors++; $display("FAIL b2b_stall got %b/%h want 0/11", a_ready, a_out); end
        valid = 1'b0; rdy = 1'b1;
        tick();
        checks++; if (a_valid !== 1'b1 || a_out !== 8'h22) begin errors++; $display("FAIL b2b_second got %b/%h want 1/22", a_valid, a_out); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_reopen got %b want 1", a_ready); end
        tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop3 got %b want 0", a_valid); end
        checks++; if (a_sticky !== 1'b0) begin errors++; $display("FAIL b2b_noerr got %b want 0", a_sticky); end
    endtask

    task automatic test_throughput();
        logic [7:0] exp [4];
        logic [3:0] sels [4];
        exp  = '{8'h44, 8'h11, 8'h33, 8'h22};
        sels = '{4'b1000, 4'b0001, 4'b0100, 4'b0010};
        in_d = {8'h11, 8'h22, 8'h33, 8'h44}; rdy = 1'b1; valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel = sels[k];
            tick();
            checks++; if (a_valid !== 1'b1 || a_out !== exp[k]) begin errors++; $display("FAIL stream%0d got %b/%h want 1/%h", k, a_valid, a_out, exp[k]); end
        end
        valid = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        logic [1:0] want;
        rdy = 1'b1; sel = 4'b0011; valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            want = (k > 3) ? 2'd3 : 2'(k);
            checks++; if (a_cnt !== want || a_err !== 1'b1) begin errors++; $display("FAIL sat%0d got %0d/%b want %0d/1", k, a_cnt, a_err, want); end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0; valid = 1'b0;
        checks++; if (a_cnt !== 2'd1 || a_sticky !== 1'b1) begin errors++; $display("FAIL clr_new got %0d/%b want 1/1", a_cnt, a_sticky); end
        tick();
        checks++; if (a_err !== 1'b0 || a_cnt !== 2'd1) begin errors++; $display("FAIL sat_after got %b/%0d want 0/1", a_err, a_cnt); end
    endtask

    task automatic test_reset_mid();
        in_d = {8'h11, 8'h22, 8'h33, 8'h44}; rdy = 1'b0; valid = 1'b1; sel = 4'b0001;
        tick();
        sel = 4'b0010;
        tick();
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL mid_two got %b want 0", a_ready); end
        valid = 1'b0; rst = 1'b1;
        tick();
        checks++; if (a_valid !== 1'b0 || a_ready !== 1'b0) begin errors++; $display("FAIL mid_rst got %b/%b want 0/0", a_valid, a_ready); end
        checks++; if ({a_sticky, a_cnt} !== 3'b000) begin errors++; $display("FAIL mid_err got %b want 000", {a_sticky, a_cnt}); end
        rst = 1'b0; rdy = 1'b1;
        tick();
        checks++; if (a_ready !== 1'b1 || a_valid !== 1'b0) begin errors++; $display("FAIL mid_rel got %b/%b want 1/0", a_ready, a_valid); end
        tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got %b want 0", a_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multihot();
        test_zero_hot();
        test_back_to_back();
        test_throughput();
        test_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prim_onehot_mux_pipe.md
PRIM_ONEHOT_MUX_PIPE -- requirements
Module: prim_onehot_mux_pipe

Interface
REQ-001 Parameter Width, default 32, data bits per input channel.
REQ-002 Parameter Inputs, default 8, number of input channels (>=2).
REQ-003 Parameter ZeroHotOk, default 0; when 1, an all-zero select is legal and yields zero data.
REQ-004 Parameter CntWidth, default 8, width of the select-error counter.
REQ-005 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_i  input  1  reset, synchronous and active-high.
REQ-007 in_i  input  Inputs*Width  channel i at bits [((Inputs-1-i)*Width) +: Width].
REQ-008 sel_i  input  Inputs  one-hot channel select, bit i selects channel i.
REQ-009 valid_i  input  1  upstream beat valid.
REQ-010 ready_o  output  1  block can accept a beat.
REQ-011 out_o  output  Width  selected data, registered.
REQ-012 valid_o  output  1  out_o holds a beat.
REQ-013 ready_i  input  1  downstream accepts out_o.
REQ-014 err_o  output  1  one-cycle pulse: accepted beat had an illegal select.
REQ-015 err_sticky_o  output  1  latched error flag.
REQ-016 err_cnt_o  output  CntWidth  saturating count of illegal-select beats.
REQ-017 err_clr_i  input  1  clears err_sticky_o and err_cnt_o.

Function
REQ-018 Mux data = bitwise OR over i of (channel i AND replicated sel_i[i]); multi-hot selects yield the OR of the selected channels.
REQ-019 Illegal select: popcount(sel_i) > 1, or popcount(sel_i) == 0 when ZeroHotOk == 0.
REQ-020 A beat is accepted when valid_i && ready_o; sel_i and in_i are sampled only then.
REQ-021 Output stage is a 2-entry skid buffer (main + skid register); latency accept-to-valid_o is exactly 1 cycle.
REQ-022 ready_o is driven from a register: ready_o = 1 iff the skid entry is empty.
REQ-023 States: EMPTY (valid_o=0), ONE (main full), TWO (main+skid full, ready_o=0).
REQ-024 EMPTY->ONE on accept; ONE->EMPTY on ready_i with no accept; ONE->ONE on accept and ready_i; ONE->TWO on accept without ready_i; TWO->ONE on ready_i (skid moves to main).
REQ-025 Sustained valid_i and ready_i gives one beat per cycle, no bubbles.
REQ-026 Beats leave in acceptance order; out_o stable while valid_o && !ready_i.
REQ-027 err_o asserts the cycle after an illegal-select beat is accepted, for one cycle, independent of ready_i.
REQ-028 err_sticky_o sets with err_o; err_cnt_o increments with err_o, saturating at all-ones.
REQ-029 err_clr_i coinciding with a new error: clear wins for that cycle, then the new error is counted (sticky=1, cnt=1).
REQ-030 No combinational path from valid_i or ready_i to ready_o.

Reset
REQ-031 While rst_i is high: state EMPTY, valid_o=0, ready_o=0, err_o=0, err_sticky_o=0, err_cnt_o=0, out_o=0.
REQ-032 First cycle after rst_i deasserts: ready_o=1.
REQ-033 Reset mid-transfer discards buffered beats; no beat emitted after reset.

Structure
REQ-034 The onehot validity check (popcount compare) lives in a shared package function alongside the state encoding typedef.
REQ-035 The 2-entry skid buffer is the single sub-module, prim_skid_buf, parametrised by payload width (Width+1 incl. error bit).

Verification
REQ-036 Inputs=4,Width=8, channels 0x11,0x22,0x33,0x44, sel=0100, ready_i=1 -> out_o=0x33, valid_o one cycle after accept, err_o=0.
REQ-037 sel=0110 with channels 1=0x0F,2=0xF0 -> out_o=0xFF, err_o pulse, err_cnt_o=1, err_sticky_o=1.
REQ-038 ready_i=0, three beats offered back-to-back -> two accepted, ready_o=0 from cycle after second accept; release ready_i -> both emitted in order.
REQ-039 sel=0000, ZeroHotOk=0 -> err_o pulse, out_o=0; ZeroHotOk=1 -> out_o=0, no error.
REQ-040 CntWidth=2, five illegal beats -> err_cnt_o saturates at 3; err_clr_i simultaneous with sixth -> cnt=1 next cycle.
REQ-041 rst_i asserted in state TWO -> valid_o=0 next cycle, no stale beat after release, ready_o=1 one cycle after deassert.
